// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the multi-cycle RV32I core: major opcodes, funct7
// patterns, ALU operation codes ({alt, funct3}), the decode FSM state type,
// the immediate-format selector and a small legality helper for OP-IMM shifts.
// No ports; imported with "import core_pkg::*;".
// ---------------------------------------------------------------------------
package core_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct7 patterns accepted on register-register ops and shifts
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes, laid out as {alt, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Decode FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Immediate format chosen by the opcode; FMT_NONE marks an unknown opcode
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } imm_fmt_t;

  // OP-IMM legality: SLLI needs funct7 = 0, SRLI/SRAI allow 0 or 0100000.
  // Non-shift OP-IMM encodings carry immediate bits there, so anything goes.
  function automatic logic opimm_legal(input logic [2:0] f3, input logic [6:0] f7);
    logic ok;
    ok = 1'b1;
    if (f3 == 3'b001) begin
      ok = (f7 == F7_BASE);
    end else if (f3 == 3'b101) begin
      ok = (f7 == F7_BASE) || (f7 == F7_ALT);
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Purely combinational immediate generator. Picks the RV32I immediate format
// from the opcode and assembles the sign-extended immediate.
// Ports:
//   command  in  32    instruction word
//   imm      out XLEN  sign-extended immediate (0 for R format / unknown)
//   fmt      out       format selected for this opcode (FMT_NONE if unknown)
// ---------------------------------------------------------------------------
module imm_gen
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     command,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt
);

  logic [31:0] imm32;

  // Map the major opcode onto its immediate format
  always_comb begin
    fmt = FMT_NONE;
    case (command[6:0])
      OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
      OPC_JAL:                       fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
      OPC_BRANCH:                    fmt = FMT_B;
      OPC_STORE:                     fmt = FMT_S;
      OPC_OP:                        fmt = FMT_R;
      default:                       fmt = FMT_NONE;
    endcase
  end

  // Assemble the 32-bit immediate; B and J have an implicit zero LSB
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{command[31]}}, command[31:20]};
      FMT_S: imm32 = {{20{command[31]}}, command[31:25], command[11:7]};
      FMT_B: imm32 = {{19{command[31]}}, command[31], command[7],
                      command[30:25], command[11:8], 1'b0};
      FMT_U: imm32 = {command[31:12], 12'b0};
      FMT_J: imm32 = {{11{command[31]}}, command[31], command[19:12],
                      command[20], command[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen to XLEN by replicating the sign bit
  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode
// Instruction decode stage of the multi-cycle RV32I core. On an accepted
// enable it latches the instruction's decoded fields and PC, strobes the
// register file, waits one cycle for the read data, captures the operands and
// pulses done. All outputs are registered and hold until the next accepted
// enable.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   enable                start pulse (ignored while busy)
//   command, pc           instruction word and its PC from fetch
//   done, busy            completion pulse / transaction in progress
//   rs_re, rs1_addr,
//   rs2_addr              register-file read strobe and indices
//   rs1_data, rs2_data    register-file data, valid the cycle after rs_re
//   pc_out, rd_addr, imm,
//   src1, src2, funct3,
//   alu_op, reg_we        decoded bundle
//   is_*                  one-hot instruction-class flags
//   illegal               unsupported encoding (all class flags then 0)
// ---------------------------------------------------------------------------
module decode
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           command,
  input  logic [XLEN-1:0]       pc,
  output logic                  done,
  output logic                  busy,
  output logic                  rs_re,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       pc_out,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       imm,
  output logic [XLEN-1:0]       src1,
  output logic [XLEN-1:0]       src2,
  output logic [2:0]            funct3,
  output logic [3:0]            alu_op,
  output logic                  reg_we,
  output logic                  is_lui,
  output logic                  is_auipc,
  output logic                  is_jal,
  output logic                  is_jalr,
  output logic                  is_branch,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  is_alu_imm,
  output logic                  is_alu_reg,
  output logic                  illegal
);

  state_t state;

  // Raw instruction fields of the incoming word
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;

  assign opcode = command[6:0];
  assign f3     = command[14:12];
  assign f7     = command[31:25];
  assign rd     = command[11:7];

  // Decoded values of the incoming word, registered only on acceptance
  logic [XLEN-1:0] imm_next;
  imm_fmt_t        fmt;
  logic            n_lui, n_auipc, n_jal, n_jalr, n_branch;
  logic            n_load, n_store, n_alu_imm, n_alu_reg;
  logic            n_illegal;
  logic [3:0]      n_alu_op;
  logic            n_reg_we;

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .command(command),
    .imm    (imm_next),
    .fmt    (fmt)
  );

  // Classify the incoming word. A class flag is raised only when the
  // encoding is legal, so illegal instructions end up with all flags low.
  // Unknown opcodes are recognised through the immediate generator's
  // FMT_NONE so the opcode list lives in exactly one place.
  always_comb begin
    n_lui     = 1'b0;
    n_auipc   = 1'b0;
    n_jal     = 1'b0;
    n_jalr    = 1'b0;
    n_branch  = 1'b0;
    n_load    = 1'b0;
    n_store   = 1'b0;
    n_alu_imm = 1'b0;
    n_alu_reg = 1'b0;
    n_illegal = 1'b0;
    n_alu_op  = ALU_ADD;
    case (opcode)
      OPC_LUI:   n_lui   = 1'b1;
      OPC_AUIPC: n_auipc = 1'b1;
      OPC_JAL:   n_jal   = 1'b1;
      OPC_JALR: begin
        if (f3 == 3'b000) n_jalr = 1'b1;
        else              n_illegal = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) n_illegal = 1'b1;
        else                              n_branch  = 1'b1;
      end
      OPC_LOAD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) n_illegal = 1'b1;
        else                                              n_load    = 1'b1;
      end
      OPC_STORE: begin
        if (f3 > 3'b010) n_illegal = 1'b1;
        else             n_store   = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only SRAI uses the alternate bit; other OP-IMM ops carry imm bits there
        n_alu_op = {command[30] & (f3 == 3'b101), f3};
        if (opimm_legal(f3, f7)) n_alu_imm = 1'b1;
        else                     n_illegal = 1'b1;
      end
      OPC_OP: begin
        n_alu_op = {command[30], f3};
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))
          n_alu_reg = 1'b1;
        else
          n_illegal = 1'b1;
      end
      default: ;
    endcase
    if (fmt == FMT_NONE) n_illegal = 1'b1;
  end

  // Writes to x0 are suppressed here so later stages never need to check rd
  assign n_reg_we = (n_lui | n_auipc | n_jal | n_jalr | n_load | n_alu_imm | n_alu_reg)
                    & (rd != 5'd0);

  // Decode FSM: IDLE latches the bundle and strobes the register file,
  // READ covers the register-file latency, CAPTURE takes the operands and
  // pulses done. Reset aborts any transaction without producing done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      busy       <= 1'b0;
      rs_re      <= 1'b0;
      rs1_addr   <= '0;
      rs2_addr   <= '0;
      pc_out     <= '0;
      rd_addr    <= '0;
      imm        <= '0;
      src1       <= '0;
      src2       <= '0;
      funct3     <= '0;
      alu_op     <= '0;
      reg_we     <= 1'b0;
      is_lui     <= 1'b0;
      is_auipc   <= 1'b0;
      is_jal     <= 1'b0;
      is_jalr    <= 1'b0;
      is_branch  <= 1'b0;
      is_load    <= 1'b0;
      is_store   <= 1'b0;
      is_alu_imm <= 1'b0;
      is_alu_reg <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            pc_out     <= pc;
            rd_addr    <= rd;
            rs1_addr   <= command[19:15];
            rs2_addr   <= command[24:20];
            imm        <= imm_next;
            funct3     <= f3;
            alu_op     <= n_alu_op;
            reg_we     <= n_reg_we;
            is_lui     <= n_lui;
            is_auipc   <= n_auipc;
            is_jal     <= n_jal;
            is_jalr    <= n_jalr;
            is_branch  <= n_branch;
            is_load    <= n_load;
            is_store   <= n_store;
            is_alu_imm <= n_alu_imm;
            is_alu_reg <= n_alu_reg;
            illegal    <= n_illegal;
            rs_re      <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          rs_re <= 1'b0;
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // x0 reads as zero regardless of what the register file returns
          src1  <= (rs1_addr == '0) ? '0 : rs1_data;
          src2  <= (rs2_addr == '0) ? '0 : rs2_data;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode
// Self-checking bench for decode. A register-file model answers rs_re one
// cycle later; a transaction-level reference model predicts every output from
// the instruction-set rules and the cycle count since the accepted enable.
// ---------------------------------------------------------------------------
module tb_decode;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] command;
  logic [31:0] pc;
  logic        done, busy, rs_re;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] pc_out, imm, src1, src2;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_alu_imm, is_alu_reg, illegal;

  decode #(
    .XLEN(32),
    .REG_ADDR_W(5)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .command(command), .pc(pc),
    .done(done), .busy(busy), .rs_re(rs_re),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc_out(pc_out), .rd_addr(rd_addr), .imm(imm),
    .src1(src1), .src2(src2), .funct3(funct3), .alu_op(alu_op), .reg_we(reg_we),
    .is_lui(is_lui), .is_auipc(is_auipc), .is_jal(is_jal), .is_jalr(is_jalr),
    .is_branch(is_branch), .is_load(is_load), .is_store(is_store),
    .is_alu_imm(is_alu_imm), .is_alu_reg(is_alu_reg), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file: raw storage, answers a strobe one cycle later and
  // returns noise on every other cycle so a mistimed capture shows up.
  logic [31:0] regs [32];

  always @(posedge clk) begin
    if (rs_re) begin
      rs1_data <= regs[rs1_addr];
      rs2_data <= regs[rs2_addr];
    end else begin
      rs1_data <= $urandom;
      rs2_data <= $urandom;
    end
  end

  // Reference model: what the decoded bundle must be for one instruction
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  aluop;
    logic        we;
    logic [8:0]  flags;   // bit order: lui auipc jal jalr branch load store opimm op
    logic        ill;
  } bundle_t;

  logic [6:0] opTable [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  function automatic bundle_t decodeModel(input logic [31:0] c, input logic [31:0] p);
    bundle_t b;
    int cls;
    logic legal;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] s;
    logic [31:0] sign;
    f3 = c[14:12];
    f7 = c[31:25];
    s = c;
    sign = 32'(s >>> 31);
    cls = -1;
    for (int i = 0; i < 9; i++) if (c[6:0] == opTable[i]) cls = i;
    b.pc = p;
    b.rd = c[11:7];
    b.rs1 = c[19:15];
    b.rs2 = c[24:20];
    b.f3 = f3;
    case (cls)
      0, 1:    b.imm = c & 32'hFFFF_F000;
      2:       b.imm = (sign << 20) | (32'(c[19:12]) << 12) | (32'(c[20]) << 11) | (32'(c[30:21]) << 1);
      3, 5, 7: b.imm = 32'(s >>> 20);
      4:       b.imm = (sign << 12) | (32'(c[7]) << 11) | (32'(c[30:25]) << 5) | (32'(c[11:8]) << 1);
      6:       b.imm = (32'(s >>> 25) << 5) | 32'(c[11:7]);
      default: b.imm = 32'd0;
    endcase
    case (cls)
      -1:      legal = 1'b0;
      3:       legal = (f3 == 3'd0);
      4:       legal = !(f3 inside {3'd2, 3'd3});
      5:       legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      6:       legal = (f3 <= 3'd2);
      7:       legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                       (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
      8:       legal = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
      default: legal = 1'b1;
    endcase
    if (cls == 8)      b.aluop = {c[30], f3};
    else if (cls == 7) b.aluop = {c[30] & (f3 == 3'd5), f3};
    else               b.aluop = 4'd0;
    b.ill = !legal;
    b.flags = legal ? (9'd1 << cls) : 9'd0;
    b.we = legal && (cls inside {0, 1, 2, 3, 5, 7, 8}) && (c[11:7] != 5'd0);
    return b;
  endfunction

  // Transaction timeline: the bundle appears on the accepting edge, rs_re is
  // high for age 0, busy for ages 0-1, done and operand capture at age 2.
  int          cyc = 0;
  int          accCyc = -1000;
  bit          haveBundle = 0;
  bit          started = 0;
  bundle_t     expB;
  bundle_t     zeroB;
  logic [31:0] pendSrc1, pendSrc2;
  logic [31:0] curSrc1 = 0, curSrc2 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      started    <= 1'b1;
      haveBundle <= 1'b0;
      accCyc     <= -1000;
      curSrc1    <= 32'd0;
      curSrc2    <= 32'd0;
    end else begin
      if (enable && (cyc + 1 - accCyc >= 3)) begin
        accCyc     <= cyc + 1;
        expB       <= decodeModel(command, pc);
        haveBundle <= 1'b1;
        pendSrc1   <= (command[19:15] == 5'd0) ? 32'd0 : regs[command[19:15]];
        pendSrc2   <= (command[24:20] == 5'd0) ? 32'd0 : regs[command[24:20]];
      end
      if (haveBundle && (cyc + 1 - accCyc == 2)) begin
        curSrc1 <= pendSrc1;
        curSrc2 <= pendSrc2;
      end
    end
  end

  // Compare every output against the model on each falling edge
  int      age;
  bundle_t cur;

  always @(negedge clk) begin
    if (started) begin
      age = cyc - accCyc;
      cur = haveBundle ? expB : zeroB;
      checkOutput("done",     32'(done),  32'(haveBundle && age == 2));
      checkOutput("busy",     32'(busy),  32'(haveBundle && age < 2));
      checkOutput("rs_re",    32'(rs_re), 32'(haveBundle && age == 0));
      checkOutput("rs1_addr", 32'(rs1_addr), 32'(cur.rs1));
      checkOutput("rs2_addr", 32'(rs2_addr), 32'(cur.rs2));
      checkOutput("pc_out",   pc_out, cur.pc);
      checkOutput("rd_addr",  32'(rd_addr), 32'(cur.rd));
      checkOutput("imm",      imm, cur.imm);
      checkOutput("funct3",   32'(funct3), 32'(cur.f3));
      checkOutput("alu_op",   32'(alu_op), 32'(cur.aluop));
      checkOutput("reg_we",   32'(reg_we), 32'(cur.we));
      checkOutput("flags",    32'({is_alu_reg, is_alu_imm, is_store, is_load, is_branch,
                                   is_jalr, is_jal, is_auipc, is_lui}), 32'(cur.flags));
      checkOutput("illegal",  32'(illegal), 32'(cur.ill));
      checkOutput("src1",     src1, curSrc1);
      checkOutput("src2",     src2, curSrc2);
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Load operands, present one instruction for one cycle; returns just
  // after the accepting edge with enable already dropped.
  task automatic applyStimulus(input logic [31:0] cmd, input logic [31:0] pcv,
                               input logic [31:0] r1, input logic [31:0] r2);
    regs[cmd[19:15]] = r1;
    regs[cmd[24:20]] = r2;
    enable  = 1'b1;
    command = cmd;
    pc      = pcv;
    @(negedge clk);
    enable  = 1'b0;
  endtask

  task automatic countDone(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  function automatic logic [31:0] randCmd();
    logic [31:0] c;
    int sel;
    c = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 9) c[6:0] = opTable[sel];
    if ($urandom_range(0, 1) == 1) c[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return c;
  endfunction

  bundle_t m;
  int      nDone;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    zeroB   = '{default: 0};
    rst     = 1'b1;
    enable  = 1'b0;
    command = 32'd0;
    pc      = 32'd0;
    stepCycles(3);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_imm", imm, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Hand-derived values that pin the reference model
    m = decodeModel(32'hFFB10093, 32'h100);
    checkOutput("model_addi_imm", m.imm, 32'hFFFF_FFFB);
    checkOutput("model_addi_flags", 32'(m.flags), 32'h080);
    m = decodeModel(32'h00532423, 32'h0);
    checkOutput("model_sw_imm", m.imm, 32'd8);
    m = decodeModel(32'hFE000EE3, 32'h0);   // BEQ x0,x0,-4
    checkOutput("model_beq_imm", m.imm, 32'hFFFF_FFFC);
    m = decodeModel(32'hFFDFF0EF, 32'h0);   // JAL x1,-4
    checkOutput("model_jal_imm", m.imm, 32'hFFFF_FFFC);
    m = decodeModel(32'h40115093, 32'h0);   // SRAI x1,x2,1
    checkOutput("model_srai_aluop", 32'(m.aluop), 32'hD);

    $display("[TB] directed: ADDI x1,x2,-5");
    applyStimulus(32'hFFB10093, 32'h100, 32'd7, 32'd0);
    checkOutput("addi_rs_re", 32'(rs_re), 32'd1);
    checkOutput("addi_rs1_addr", 32'(rs1_addr), 32'd2);
    stepCycles(2);
    checkOutput("addi_done", 32'(done), 32'd1);
    checkOutput("addi_imm", imm, 32'hFFFF_FFFB);
    checkOutput("addi_rd", 32'(rd_addr), 32'd1);
    checkOutput("addi_is_alu_imm", 32'(is_alu_imm), 32'd1);
    checkOutput("addi_alu_op", 32'(alu_op), 32'd0);
    checkOutput("addi_src1", src1, 32'd7);
    checkOutput("addi_reg_we", 32'(reg_we), 32'd1);
    checkOutput("addi_pc_out", pc_out, 32'h100);

    $display("[TB] directed: SUB x3,x1,x2");
    applyStimulus(32'h402081B3, 32'h104, 32'd10, 32'd3);
    stepCycles(2);
    checkOutput("sub_alu_op", 32'(alu_op), 32'h8);
    checkOutput("sub_is_alu_reg", 32'(is_alu_reg), 32'd1);
    checkOutput("sub_src1", src1, 32'd10);
    checkOutput("sub_src2", src2, 32'd3);
    checkOutput("sub_imm", imm, 32'd0);

    $display("[TB] directed: SW x5,8(x6)");
    applyStimulus(32'h00532423, 32'h108, $urandom, $urandom);
    stepCycles(2);
    checkOutput("sw_is_store", 32'(is_store), 32'd1);
    checkOutput("sw_imm", imm, 32'd8);
    checkOutput("sw_funct3", 32'(funct3), 32'd2);
    checkOutput("sw_reg_we", 32'(reg_we), 32'd0);
    checkOutput("sw_rs1_addr", 32'(rs1_addr), 32'd6);
    checkOutput("sw_rs2_addr", 32'(rs2_addr), 32'd5);

    $display("[TB] directed: LUI x7,0x12345 with a second enable while reading");
    applyStimulus(32'h123453B7, 32'h10C, $urandom, $urandom);
    enable  = 1'b1;
    command = 32'h00000013;
    @(negedge clk);
    enable  = 1'b0;
    countDone(5, nDone);
    checkOutput("lui_done_count", 32'(nDone), 32'd1);
    checkOutput("lui_imm", imm, 32'h1234_5000);
    checkOutput("lui_is_lui", 32'(is_lui), 32'd1);

    $display("[TB] directed: x0 operands, then an unknown opcode");
    applyStimulus(32'h00000033, 32'h110, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    stepCycles(2);
    checkOutput("x0_src1", src1, 32'd0);
    checkOutput("x0_reg_we", 32'(reg_we), 32'd0);
    applyStimulus(32'hFFFF_FFFF, 32'h114, $urandom, $urandom);
    stepCycles(1);
    checkOutput("ill_done_early", 32'(done), 32'd0);
    stepCycles(1);
    checkOutput("ill_done", 32'(done), 32'd1);
    checkOutput("ill_illegal", 32'(illegal), 32'd1);
    checkOutput("ill_flags", 32'({is_alu_reg, is_alu_imm, is_store, is_load, is_branch,
                                  is_jalr, is_jal, is_auipc, is_lui}), 32'd0);

    $display("[TB] directed: reset during READ");
    applyStimulus(32'hFFB10093, 32'h200, 32'd5, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_pc_out", pc_out, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_imm", imm, 32'd0);
    countDone(4, nDone);
    checkOutput("rst_no_done", 32'(nDone), 32'd0);
    applyStimulus(32'h402081B3, 32'h204, 32'd20, 32'd6);
    stepCycles(2);
    checkOutput("post_rst_done", 32'(done), 32'd1);
    checkOutput("post_rst_src1", src1, 32'd20);

    $display("[TB] randomized phase");
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      enable  = ($urandom_range(0, 2) != 0);
      command = randCmd();
      pc      = $urandom;
      @(negedge clk);
    end
    rst    = 1'b0;
    enable = 1'b0;
    stepCycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
